add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes; legal range 2..8; W = 8*NBYTES.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a new operation; sampled only when ready=1.
REQ-005 sub  input  1  operation select: 0 = a+b, 1 = a-b.
REQ-006 a  input  W  operand A, unsigned or two's complement.
REQ-007 b  input  W  operand B, unsigned or two's complement.
REQ-008 ready  output  1  high when a start is accepted this cycle (state IDLE or DONE).
REQ-009 busy  output  1  high while byte additions are in progress (state RUN).
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 sum  output  W  result, held stable from done until the next accepted start.
REQ-012 c_out  output  1  carry out of bit W-1 (for sub: 1 = no borrow).
REQ-013 overflow  output  1  signed overflow of the W-bit operation.

Function
REQ-014 The block SHALL time-share one 8-bit add-with-carry stage, one byte per cycle, LSB byte first.
REQ-015 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE/DONE + start=1: latch a, sub ? ~b : b, carry_reg <= sub, idx <= 0; next state RUN.
REQ-017 IDLE + start=0: stay IDLE.
REQ-018 DONE + start=0: go to IDLE; done deasserts.
REQ-019 RUN: each edge, {carry, sum byte idx} <= A[idx] + Bx[idx] + carry_reg; carry_reg <= carry; idx <= idx+1.
REQ-020 RUN with idx = NBYTES-1: write last byte; c_out <= carry; overflow <= (A[W-1] == Bx[W-1]) && (result bit W-1 != A[W-1]); next state DONE.
REQ-021 Latency: start accepted at edge k -> done=1 in the cycle after edge k+NBYTES; NBYTES+1 cycles from accept to done.
REQ-022 Back-to-back: start=1 during done cycle SHALL be accepted; done and busy never high together.
REQ-023 start while busy=1 SHALL be ignored; latched operands and sub unaffected by input changes during RUN.
REQ-024 sum bytes not yet written in RUN SHALL hold prior values; sum/c_out/overflow only guaranteed valid while done=1 and after until next accept.
REQ-025 All arithmetic modulo 2^W; carry chain crosses byte boundaries only via carry_reg.
REQ-026 ready = (state==IDLE) || (state==DONE); busy = (state==RUN); both combinational from state.

Reset
REQ-027 reset=1 SHALL force state IDLE, idx 0, carry_reg 0, done 0, sum 0, c_out 0, overflow 0 on the next edge.
REQ-028 reset SHALL take priority over start and abort any RUN in progress; no done pulse for the aborted operation.
REQ-029 First start SHALL be accepted on the first edge with reset=0.

Verification (NBYTES=4)
REQ-030 a=0x000000FF, b=0x00000001, sub=0, start 1 cycle -> done 5 cycles later; sum=0x00000100, c_out=0, overflow=0.
REQ-031 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, c_out=1, overflow=0 (full carry ripple across all 4 bytes).
REQ-032 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, c_out=0, overflow=1; a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, c_out=0, overflow=0.
REQ-033 start held high continuously with changing operands -> ops accepted only in IDLE/DONE, one done per op every 5 cycles, results match operands latched at accept; mid-RUN operand changes ignored.
REQ-034 reset asserted 2 cycles into RUN -> next cycle state IDLE, sum=0, done never pulses; new start then completes normally.
REQ-035 Random scoreboard: 10k random a, b, sub, random start gaps -> every done matches reference {c_out,sum}=a±b, overflow per REQ-020.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Byte-serial adder/subtractor: one shared 8-bit add-with-carry stage processes the
// operands LSB byte first, then pulses done with sum, carry out and signed overflow.
module add_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_sub,
    input  logic [8*NBYTES-1:0]   i_a,
    input  logic [8*NBYTES-1:0]   i_b,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [8*NBYTES-1:0]   o_sum,
    output logic                  o_c_out,
    output logic                  o_overflow
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_bx;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_sum;
    logic            r_c_out;
    logic            r_overflow;

    state_e          w_state_nxt;
    logic [W-1:0]    w_a_nxt;
    logic [W-1:0]    w_bx_nxt;
    logic            w_carry_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic [W-1:0]    w_sum_nxt;
    logic            w_c_out_nxt;
    logic            w_overflow_nxt;

    logic [7:0]      w_byte_a;
    logic [7:0]      w_byte_b;
    logic [8:0]      w_add;

    // The single shared byte stage; B is already inverted for subtraction at accept.
    always_comb begin
        w_byte_a = r_a[{r_idx, 3'b000} +: 8];
        w_byte_b = r_bx[{r_idx, 3'b000} +: 8];
        w_add    = {1'b0, w_byte_a} + {1'b0, w_byte_b} + {8'd0, r_carry};
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_bx_nxt       = r_bx;
        w_carry_nxt    = r_carry;
        w_idx_nxt      = r_idx;
        w_sum_nxt      = r_sum;
        w_c_out_nxt    = r_c_out;
        w_overflow_nxt = r_overflow;

        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_a_nxt     = i_a;
                    w_bx_nxt    = i_sub ? ~i_b : i_b;
                    w_carry_nxt = i_sub;
                    w_idx_nxt   = '0;
                    w_state_nxt = StRun;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StRun: begin
                w_sum_nxt[{r_idx, 3'b000} +: 8] = w_add[7:0];
                w_carry_nxt = w_add[8];
                w_idx_nxt   = r_idx + 1'b1;
                if (r_idx == LastIdx) begin
                    w_idx_nxt      = '0;
                    w_c_out_nxt    = w_add[8];
                    // Bit 7 of the last byte is result bit W-1.
                    w_overflow_nxt = (r_a[W-1] == r_bx[W-1]) && (w_add[7] != r_a[W-1]);
                    w_state_nxt    = StDone;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_a        <= '0;
            r_bx       <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_bx       <= w_bx_nxt;
            r_carry    <= w_carry_nxt;
            r_idx      <= w_idx_nxt;
            r_sum      <= w_sum_nxt;
            r_c_out    <= w_c_out_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign o_ready    = (r_state == StIdle) || (r_state == StDone);
    assign o_busy     = (r_state == StRun);
    assign o_done     = (r_state == StDone);
    assign o_sum      = r_sum;
    assign o_c_out    = r_c_out;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: directed vector table, back-to-back and reset-abort sequences,
// and a random stream, all checked against a whole-word reference model via a scoreboard.
module tb_add_seq_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          overflow;

    add_seq_ctrl #(.NBYTES(NB)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_sub      (sub),
        .i_a        (a),
        .i_b        (b),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum      (sum),
        .o_c_out    (c_out),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
        int unsigned  due;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input int unsigned due);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   full;
        bx    = msub ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, msub};
        e.sum = full[W-1:0];
        e.c   = full[W];
        e.ovf = (ma[W-1] == bx[W-1]) && (full[W-1] != ma[W-1]);
        e.due = due;
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, when inputs and outputs are both settled.
    logic         mon_en   = 1'b0;
    logic [W-1:0] held_sum = '0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done) begin
                check("done_busy_exclusive", busy, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done=1 with no op outstanding (cycle %0d)",
                             cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_sum", sum, e.sum);
                    check("sb_c_out", c_out, e.c);
                    check("sb_overflow", overflow, e.ovf);
                    check("sb_latency", cyc, e.due);
                end
                held_sum = sum;
            end else if (ready) begin
                check("idle_sum_hold", sum, held_sum);
            end
            if (reset) begin
                sb_q.delete();
                held_sum = '0;
            end else if (start && ready) begin
                sb_q.push_back(model(a, b, sub, cyc + 1 + NB));
            end
        end
    end

    // Called in the post-posedge phase; returns just after the accepting edge, with
    // the inputs scrambled to show that only the latched operands matter.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
        int n;
        n     = 0;
        a     = ta;
        b     = tb_;
        sub   = ts;
        start = 1'b1;
        forever begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: ready never rose (cycle %0d)", cyc);
                start = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_;
        sub   = ~ts;
        check("accept_busy", busy, 1'b1);
    endtask

    task automatic wait_done(output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
            n++;
            if (n > NB + 3) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", n, cyc);
                return;
            end
        end
    endtask

    task automatic run_vec(input int i);
        logic ok;
        issue(vecs[i].a, vecs[i].b, vecs[i].sub);
        wait_done(ok);
        if (ok) begin
            check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            check($sformatf("vec%0d_c_out", i), c_out, vecs[i].c);
            check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = '1;
        b     = '1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
        end
        #2;
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_c_out", c_out, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // First edge with reset low must accept the start (issue checks busy right after).
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // start held high with operands changing every cycle: back-to-back accepts.
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        repeat (NB + 3) begin
            @(posedge clk);
        end
        #2;

        // Reset two cycles into RUN aborts without a done pulse.
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_ready", ready, 1'b1);
        check("abort_done", done, 1'b0);
        check("abort_sum", sum, '0);
        check("abort_c_out", c_out, 1'b0);
        check("abort_overflow", overflow, 1'b0);
        repeat (2 * NB) begin
            @(posedge clk);
        end
        #2;
        run_vec(2);

        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            int           gap;
            gap = $urandom_range(0, 1);
            repeat (gap) begin
                @(posedge clk);
                #2;
            end
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs);
        end
        repeat (NB + 4) begin
            @(posedge clk);
        end
        #2;
        check("queue_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
